duft_req_arbiter: RTL and testbench



---
 rtl/duft_arb_pkg.sv | 14 +
 rtl/duft_rr_arbiter.sv | 37 +++
 rtl/duft_req_arbiter.sv | 118 +++++++++++
 tb/tb_duft_req_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/duft_arb_pkg.sv
// duft_arb_pkg: shared state encodings and default widths
// for the ap_ctrl_hs request arbiter.
package duft_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int DEF_N_REQ   = 2;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/duft_rr_arbiter.sv
// duft_rr_arbiter: combinational round-robin pick, search
// starts just after last_grant; pointer lives in the parent.
module duft_rr_arbiter
  import duft_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  int          j;
  logic [IW-1:0] jj;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = int'(last_grant) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IW'(j);
      if (!any && req_valid[jj]) begin
        any       = 1'b1;
        idx       = jj;
        grant[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/duft_req_arbiter.sv
// duft_req_arbiter: round-robin sharing of one ap_ctrl_hs
// port between N_REQ requesters, with watchdog abort.
module duft_req_arbiter
  import duft_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    ap_rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_rd_wr,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    m_ap_start,
  output logic                    m_rd_wr,
  output logic [ADDR_W-1:0]       m_addr,
  output logic [DATA_W-1:0]       m_wr_data,
  input  logic                    m_ap_idle,
  input  logic                    m_ap_ready,
  input  logic                    m_ap_done,
  input  logic [DATA_W-1:0]       m_ap_return
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [N_REQ-1:0] ONE =
    {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]       state_q;
  logic [IW-1:0]    last_q;
  logic [IW-1:0]    gnt_q;
  logic [CW-1:0]    wdog_q;
  logic [N_REQ-1:0] arb_oh;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic             fire;

  duft_rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .req_valid  (req_valid),
    .last_grant (last_q),
    .grant      (arb_oh),
    .idx        (arb_idx),
    .any        (arb_any)
  );

  assign fire = !ap_rst && (state_q == ST_IDLE)
              && arb_any && m_ap_idle;

  assign req_ready  = fire ? arb_oh : '0;
  assign m_ap_start = (state_q == ST_BUSY);
  assign rsp_valid  = (state_q == ST_RESP)
                    ? (ONE << gnt_q) : '0;

  always_ff @(posedge clk) begin
    if (ap_rst) begin
      state_q   <= ST_IDLE;
      last_q    <= IW'(N_REQ - 1);
      gnt_q     <= '0;
      wdog_q    <= '0;
      m_rd_wr   <= 1'b0;
      m_addr    <= '0;
      m_wr_data <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (1'b1)
        state_q == ST_IDLE: begin
          if (fire) begin
            m_rd_wr   <= req_rd_wr[arb_idx];
            m_addr    <= req_addr[arb_idx*ADDR_W +: ADDR_W];
            m_wr_data <= req_wdata[arb_idx*DATA_W +: DATA_W];
            gnt_q     <= arb_idx;
            last_q    <= arb_idx;
            wdog_q    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            state_q   <= ST_BUSY;
          end
        end
        state_q == ST_BUSY: begin
          // done beats a timeout landing on the same edge
          if (m_ap_done) begin
            rsp_data <= m_rd_wr ? m_ap_return : '0;
            rsp_err  <= 1'b0;
            state_q  <= ST_RESP;
          end else if (wdog_q == CW'(TIMEOUT - 1)) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state_q  <= ST_RESP;
          end else if (wdog_q != CW'(TIMEOUT)) begin
            wdog_q <= wdog_q + CW'(1);
          end
        end
        default: begin
          if (rsp_ready[gnt_q]) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!ap_rst && m_ap_start)
      assert (m_ap_ready == m_ap_done);
  end

endmodule

// File: tb/tb_duft_req_arbiter.sv
// tb_duft_req_arbiter: directed + random stimulus against a
// transaction-level round-robin/latency reference model.
module tb_duft_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            ap_rst;
  logic [N-1:0]    req_valid, req_rd_wr, req_ready;
  logic [N-1:0]    rsp_valid, rsp_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_data, m_wr_data, m_ap_return;
  logic [AW-1:0]   m_addr;
  logic            rsp_err, m_ap_start, m_rd_wr;
  logic            m_ap_idle, m_ap_ready, m_ap_done;

  logic idle_in;
  int   wmode, wdly, w_cnt, d_now;
  int   n_cmp, n_bad, cyc;

  bit          inflight;
  int          win, g, lat, ptr;
  logic        exp_rd, exp_err;
  logic [AW-1:0] exp_ma;
  logic [DW-1:0] exp_md, exp_data;
  int          glog_w[$], glog_c[$];

  duft_req_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_rd_wr(req_rd_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .m_ap_start(m_ap_start),
    .m_rd_wr(m_rd_wr), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_ap_idle(m_ap_idle),
    .m_ap_ready(m_ap_ready), .m_ap_done(m_ap_done),
    .m_ap_return(m_ap_return)
  );

  always #5 clk = ~clk;

  // wrapper model: done after d_now BUSY cycles
  assign d_now = (wmode != 0) ? wdly : (m_rd_wr ? 2 : 3);
  assign m_ap_done = m_ap_start && (w_cnt == d_now - 1);
  assign m_ap_ready = m_ap_done;
  assign m_ap_idle = idle_in;
  assign m_ap_return = m_ap_done
                     ? {16'hCAFE, m_addr[15:0]} : '0;
  always @(posedge clk) w_cnt <= m_ap_start ? w_cnt + 1 : 0;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               tag, cyc, obs, exp);
    end
  endtask

  function automatic int rr(logic [N-1:0] v, int p);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic cycle();
    logic [N-1:0] er;
    int d;
    #1;
    if (ap_rst) begin
      chk("rst_rdy", req_ready, 0);
      inflight = 0;
      ptr = N - 1;
      exp_ma = '0;
      exp_md = '0;
      exp_rd = 1'b0;
    end else begin
      chk("m_addr", m_addr, exp_ma);
      chk("m_wdata", m_wr_data, exp_md);
      chk("m_rdwr", m_rd_wr, exp_rd);
      if (!inflight) begin
        er = '0;
        if (idle_in && |req_valid)
          er[rr(req_valid, ptr)] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("rsp_valid", rsp_valid, 0);
        chk("start_idle", m_ap_start, 0);
        if (er != 0) begin
          win = rr(req_valid, ptr);
          ptr = win;
          inflight = 1;
          g = cyc;
          exp_rd = req_rd_wr[win];
          exp_ma = req_addr[win*AW +: AW];
          exp_md = req_wdata[win*DW +: DW];
          d = (wmode != 0) ? wdly : (exp_rd ? 2 : 3);
          exp_err = (d > TO);
          lat = exp_err ? TO + 1 : d + 1;
          exp_data = exp_err ? '0 : exp_rd
                   ? {16'hCAFE, exp_ma[15:0]} : '0;
          glog_w.push_back(win);
          glog_c.push_back(cyc);
        end
      end else if (cyc < g + lat) begin
        chk("rdy_busy", req_ready, 0);
        chk("rsp_busy", rsp_valid, 0);
        chk("start_busy", m_ap_start, 1);
      end else begin
        chk("rdy_resp", req_ready, 0);
        chk("rsp_valid", rsp_valid, 1 << win);
        chk("start_resp", m_ap_start, 0);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", rsp_err, exp_err);
        if (rsp_ready[win]) inflight = 0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_req(int i, logic rd, logic [AW-1:0] a,
                         logic [DW-1:0] w);
    req_rd_wr[i] = rd;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = w;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    inflight = 0; ptr = N - 1;
    exp_ma = '0; exp_md = '0; exp_rd = 1'b0;
    exp_err = 1'b0; exp_data = '0;
    ap_rst = 1'b1; idle_in = 1'b1;
    req_valid = '0; req_rd_wr = '0;
    req_addr = '0; req_wdata = '0;
    rsp_ready = '1; wmode = 0; wdly = 0;
    run(2);
    ap_rst = 1'b0;
    chk("rst_data", rsp_data, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_start", m_ap_start, 0);

    set_req(0, 1'b1, 32'h10, 32'h0);
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    run(6);

    set_req(1, 1'b0, 32'h20, 32'h1234);
    req_valid = 4'b0010;
    cycle();
    req_valid = '0;
    run(7);

    ap_rst = 1'b1;
    cycle();
    ap_rst = 1'b0;
    glog_w.delete(); glog_c.delete();
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 32'h100 + i, 32'h0);
    req_valid = '1;
    run(20);
    req_valid = '0;
    run(4);
    chk("order_n", glog_w.size() >= 5, 1);
    for (int i = 0; i < 5 && i < glog_w.size(); i++) begin
      chk("order_w", glog_w[i], i % N);
      if (i > 0)
        chk("order_gap", glog_c[i] - glog_c[i-1], 4);
    end

    wmode = 1; wdly = 200;
    set_req(2, 1'b1, 32'h30, 32'h0);
    req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    run(22);
    wmode = 0;

    rsp_ready = 4'b0111;
    set_req(3, 1'b1, 32'h40, 32'h0);
    req_valid = 4'b1000;
    cycle();
    req_valid = 4'b0001;
    run(10);
    rsp_ready = '1;
    run(3);
    req_valid = '0;
    run(6);

    glog_w.delete(); glog_c.delete();
    set_req(1, 1'b0, 32'h50, 32'hBEEF);
    req_valid = 4'b0010;
    cycle();
    req_valid = '0;
    ap_rst = 1'b1;
    cycle();
    ap_rst = 1'b0;
    idle_in = 1'b0;
    chk("rst2_start", m_ap_start, 0);
    chk("rst2_addr", m_addr, 0);
    chk("rst2_wdata", m_wr_data, 0);
    chk("rst2_rsp", rsp_valid, 0);
    req_valid = 4'b0101;
    set_req(0, 1'b1, 32'h60, 32'h0);
    set_req(2, 1'b1, 32'h70, 32'h0);
    run(3);
    idle_in = 1'b1;
    cycle();
    req_valid = '0;
    chk("rst2_ngr", glog_w.size(), 2);
    if (glog_w.size() == 2) chk("rst2_win", glog_w[1], 0);
    run(6);

    for (int i = 0; i < 3000; i++) begin
      ap_rst = ($urandom_range(0, 199) == 0);
      if (!inflight) begin
        wmode = ($urandom_range(0, 3) == 0) ? 1 : 0;
        case ($urandom_range(0, 2))
          0: wdly = $urandom_range(2, TO + 2);
          1: wdly = TO;
          default: wdly = 200;
        endcase
      end
      idle_in = ($urandom_range(0, 3) != 0);
      req_valid = N'($urandom);
      req_rd_wr = N'($urandom);
      for (int k = 0; k < N; k++) begin
        req_addr[k*AW +: AW] = $urandom;
        req_wdata[k*DW +: DW] = $urandom;
      end
      rsp_ready = N'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
